// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    MERGE,
    RESP
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus word-memory bus of the load/store unit.
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_A;
  logic [XLEN-1:0]   mem_WD;
  logic              mem_WE;
  logic [XLEN-1:0]   mem_RD;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_A, mem_WD, mem_WE
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_A, mem_WD, mem_WE
  );

endinterface

// File: rtl/lsu_lane_fmt.sv
// Byte/half lane handling: load extract with sign/zero extension, and
// sub-word store merge into a previously read word.
module lsu_lane_fmt
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rd_word,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rd_word[{addr_lo, 3'b000} +: 8];
    half_v = rd_word[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
      F3_BU:   load_data = {24'h0, byte_v};
      F3_H:    load_data = {{16{half_v[15]}}, half_v};
      F3_HU:   load_data = {16'h0, half_v};
      default: load_data = rd_word;
    endcase
  end

  // Only the size bits matter for stores; signed/unsigned is meaningless here.
  always_comb begin
    store_word = old_word;
    case (funct3[1:0])
      2'b00:   store_word[{addr_lo, 3'b000} +: 8]      = wdata[7:0];
      2'b01:   store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store unit on a word-addressed memory; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses instead of force-aligning them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  load_store_unit_if.slave   bus
);

  lsu_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   buf_q, buf_d;
  logic              err_q, err_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic              illegal;
  logic              req_err;
  logic [ADDR_W-1:0] addr_lat;
  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   merged;
  logic              word_store;

  assign illegal = bus.req_we ? bus.req_funct3[2]
                              : (bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;

  always_comb begin
    misaligned = 1'b0;
    case (bus.req_funct3[1:0])
      2'b01:   misaligned = bus.req_addr[0];
      2'b10:   misaligned = |bus.req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign req_err  = illegal | misaligned;
  assign addr_lat = bus.req_addr;
`else
  // Misaligned requests are quietly snapped down to natural alignment.
  always_comb begin
    addr_lat = bus.req_addr;
    case (bus.req_funct3[1:0])
      2'b01:   addr_lat[0]   = 1'b0;
      2'b10:   addr_lat[1:0] = 2'b00;
      default: addr_lat      = bus.req_addr;
    endcase
  end

  assign req_err = illegal;
`endif

  lsu_lane_fmt u_lane_fmt (
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .rd_word    (bus.mem_RD),
    .old_word   (buf_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (merged)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    err_d       = err_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d     = bus.req_we;
          funct3_d = bus.req_funct3;
          addr_d   = addr_lat;
          wdata_d  = bus.req_wdata;
          err_d    = req_err;
          state_d  = req_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          buf_d   = load_data;
          state_d = RESP;
        end else if (funct3_q == F3_B || funct3_q == F3_H) begin
          buf_d   = bus.mem_RD;
          state_d = MERGE;
        end else begin
          state_d = RESP;
        end
      end
      MERGE: state_d = RESP;
      RESP: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        rsp_rdata_d = (!we_q && !err_q) ? buf_q : '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Write strobe follows state directly so an async reset kills it immediately.
  assign word_store    = (state_q == ACCESS) && we_q && (funct3_q == F3_W);
  assign bus.mem_WE    = word_store || (state_q == MERGE);
  assign bus.mem_WD    = (state_q == MERGE) ? merged : (word_store ? wdata_q : '0);
  assign bus.mem_A     = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and the word-addressed data memory (combinational read, synchronous word write, no byte enables).
- Converts RV32 loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses.
- Sub-word stores use a registered read-modify-write. Loads are extracted and extended from the word read.
- Detects misaligned and illegal requests and reports them on a registered response.

Parameters:
- ADDR_W, 32, byte address width on the request and memory sides.
- XLEN, 32, data width. Fixed at 32; other values are unsupported.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 funct3 (size/sign).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  XLEN  load result, extended; 0 for stores and errors.
- rsp_err  out  1  misaligned or illegal request (qualified by rsp_valid).
- mem_A  out  ADDR_W  memory address, always {addr[31:2],2'b00}.
- mem_WD  out  XLEN  memory write data.
- mem_WE  out  1  memory write enable.
- mem_RD  in  XLEN  memory combinational read data.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; req_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0; mem_WE=0; mem_A=0; mem_WD=0; latched request cleared.
- States:
  - IDLE: accept when req_valid && req_ready; latch we/funct3/addr/wdata.
  - ACCESS: perform the load or the word store.
  - MERGE: write the merged word for a sub-word store.
  - RESP: rsp_valid=1 for exactly one cycle, then return to IDLE.
- Transitions from IDLE on accept:
  - error detected → RESP with rsp_err=1.
  - otherwise → ACCESS.
- ACCESS:
  - Load: rsp_rdata is registered from the extracted and extended mem_RD lane.
  - SW: mem_WE=1, mem_WD=wdata.
  - SB/SH: capture mem_RD into the merge buffer, then go to MERGE.
  - All other cases go to RESP.
- MERGE: mem_WE=1. mem_WD is the buffered word with the byte/half lane selected by addr[1:0] replaced. Then go to RESP.
- Latency from accept edge T to rsp_valid:
  - error: T+1.
  - load or SW: T+2.
  - SB/SH: T+3.
- mem_WE:
  - Decoded combinationally from state only: ACCESS with SW, or MERGE.
  - Never asserted on error.
  - Never more than one write per request.
- Lanes:
  - LB/LBU use byte addr[1:0].
  - LH/LHU use half addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Illegal funct3: loads 011/110/111, stores 1xx. Always rsp_err=1, no memory access.
- Misalignment: half with addr[0]=1, or word with addr[1:0]≠0. Handling depends on the optional feature below.
- rsp_valid has no backpressure; the consumer must take it.
- req_valid while not IDLE is ignored; req_ready=0.
- Reset mid-operation: returns to IDLE immediately and mem_WE drops asynchronously. A reset asserted during MERGE before the edge causes no write.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned requests give rsp_err=1 at T+1 with no memory access.
- Undefined: the low address bits are silently forced to natural alignment and the request proceeds normally with rsp_err=0.
  - halfword: addr[0]=0.
  - word: addr[1:0]=0.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - state enum lsu_state_t {IDLE, ACCESS, MERGE, RESP}.
- Sub-module lsu_lane_fmt (combinational):
  - load extract/extend: funct3, addr[1:0], word → result.
  - store merge: funct3, addr[1:0], old word, wdata → new word.
- The FSM, registers and error logic stay in load_store_unit.

Test Plan:
- SW 0x100 ← 0xDEADBEEF, then LW 0x100 → rsp_rdata=0xDEADBEEF at T+2; exactly one mem_WE pulse for the SW.
- SB 0x101 wdata=0x12345655 → MERGE writes 0xDEAD55EF at T+2; LB 0x101 → 0x00000055; LBU 0x103 → 0x000000DE.
- LH 0x102 → 0xFFFFDEAD; LHU 0x102 → 0x0000DEAD; SH 0x102 ← 0x00000001 then LW → 0x000155EF.
- LW 0x102:
  - with LSU_MISALIGN_TRAP_EN: rsp_err=1 at T+1, mem_WE never high.
  - without: returns word at 0x100, rsp_err=0.
- funct3=011 load and funct3=100 store → rsp_err=1, rsp_rdata=0, no mem_WE.
- Assert rst_n=0 while in MERGE of SB 0x100 → mem_WE drops immediately, memory unchanged, req_ready=1 and rsp_valid=0 after reset release.
